// File: rtl/register_file_bank.sv
// Register file with write-to-read bypass and a per-register busy
// scoreboard that flags RAW hazards on loads still in flight.
module register_file_bank #(
  parameter int addressWidth = 3,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addressWidth-1:0] DA,
  input  logic [dataWidth-1:0]    D_data,
  input  logic                    write_en,
  input  logic [addressWidth-1:0] AA,
  input  logic [addressWidth-1:0] BA,
  input  logic                    A_used,
  input  logic                    B_used,
  input  logic                    claim_en,
  input  logic [addressWidth-1:0] claim_addr,
  output logic [dataWidth-1:0]    A_data,
  output logic [dataWidth-1:0]    B_data,
  output logic                    A_busy,
  output logic                    B_busy,
  output logic                    stall,
  output logic                    claim_err
);

  localparam int NREG = 2 ** addressWidth;

  logic [dataWidth-1:0] regs_q [NREG];
  logic [dataWidth-1:0] regs_d [NREG];
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;
  logic                 err_q;
  logic                 err_d;

  logic wr_ok;
  logic cl_ok;
  logic a_hit;
  logic b_hit;

  assign wr_ok = write_en && (DA != '0);
  assign cl_ok = claim_en && (claim_addr != '0);
  assign a_hit = wr_ok && (DA == AA);
  assign b_hit = wr_ok && (DA == BA);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_ok) begin
      regs_d[DA] = D_data;
      busy_d[DA] = 1'b0;
    end
    // A claim after the write so a same-edge reload leaves the reg busy
    if (cl_ok) begin
      busy_d[claim_addr] = 1'b1;
      if (busy_q[claim_addr] && !(wr_ok && (DA == claim_addr)))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    A_data = '0;
    B_data = '0;
    if (AA != '0) A_data = a_hit ? D_data : regs_q[AA];
    if (BA != '0) B_data = b_hit ? D_data : regs_q[BA];
  end

  assign A_busy    = busy_q[AA] && !a_hit && (AA != '0);
  assign B_busy    = busy_q[BA] && !b_hit && (BA != '0);
  assign stall     = (A_used && A_busy) || (B_used && B_busy);
  assign claim_err = err_q;

endmodule
